// File: rtl/res_writer_pkg.sv
// Shared definitions for the result writer: FSM states, instruction field layout
// and the AXI4 constants used when issuing write bursts.
package res_writer_pkg;

   localparam int DFLT_CORE_AXI_DATA_WIDTH = 128;
   localparam int DFLT_CORE_INSTR_WIDTH    = 64;

   localparam int INSTR_ADDR_LSB = 0;
   localparam int INSTR_ADDR_W   = 32;
   localparam int INSTR_CNT_LSB  = 32;
   localparam int INSTR_CNT_W    = 16;
   localparam int INSTR_RSVD_LSB = 48;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } res_state_e;

endpackage

// File: rtl/res_burst_calc.sv
// Picks the next AXI burst length: limited by the beats left, the maximum burst
// size and the room remaining before the next 4 KB page boundary.
module res_burst_calc
   import res_writer_pkg::*;
#(
   parameter int DATA_BYTES    = 16,
   parameter int MAX_BURST_LEN = 16
)(
   input  logic [15:0] remaining_i,
   input  logic [11:0] addr_lo_i,
   output logic [8:0]  len_o
);

   localparam int BYTE_SHIFT = $clog2(DATA_BYTES);

   logic [12:0] page_room;

   always_comb begin
      page_room = (13'd4096 - {1'b0, addr_lo_i}) >> BYTE_SHIFT;
      if (page_room > 13'(MAX_BURST_LEN)) begin
         len_o = 9'(MAX_BURST_LEN);
      end else begin
         len_o = page_room[8:0];
      end
      if (remaining_i < 16'(len_o)) begin
         len_o = remaining_i[8:0];
      end
      // An unaligned address in the last beat of a page still needs one beat to progress
      if (len_o == 9'd0) begin
         len_o = 9'd1;
      end
   end

endmodule

// File: rtl/res_writer.sv
// Result writer: takes {beat_cnt, base_addr} instructions and streams the matching
// layout-converter beats out as 4 KB-safe AXI4 INCR write bursts, one at a time.
module res_writer
   import res_writer_pkg::*;
#(
   parameter int AXI_DATA_WIDTH   = DFLT_CORE_AXI_DATA_WIDTH,
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int CORE_INSTR_WIDTH = DFLT_CORE_INSTR_WIDTH,
   parameter int MAX_BURST_LEN    = 16
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_axis_res_instr_tvalid,
   output logic                          s_axis_res_instr_tready,
   input  logic [CORE_INSTR_WIDTH-1:0]   s_axis_res_instr_tdata,
   input  logic                          s_axis_lc2res_tvalid,
   output logic                          s_axis_lc2res_tready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axis_lc2res_tdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axis_lc2res_tkeep,
   input  logic                          s_axis_lc2res_tlast,
   input  logic                          s_axis_lc2res_tuser,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic                          instr_done,
   output logic                          layer_done,
   output logic                          err_resp,
   output logic                          err_len
);

   localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
   localparam int SIZE_LOG2  = $clog2(DATA_BYTES);

   res_state_e                state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, load_addr;
   logic [15:0]               remaining_q, remaining_d, load_rem;
   logic [8:0]                len_q, len_d, beat_q, beat_d, calc_len;
   logic                      tuser_q, tuser_d;
   logic                      instr_done_q, instr_done_d;
   logic                      layer_done_q, layer_done_d;
   logic                      err_resp_q, err_resp_d;
   logic                      err_len_q, err_len_d;
   logic                      run_q;
   logic                      last_beat, final_beat;

   logic [CORE_INSTR_WIDTH-INSTR_RSVD_LSB-1:0] unused_rsvd;
   assign unused_rsvd = s_axis_res_instr_tdata[CORE_INSTR_WIDTH-1:INSTR_RSVD_LSB];

   // Address/count that a new burst starts from: the instruction in IDLE, else the post-burst values
   always_comb begin
      if (state_q == ST_IDLE) begin
         load_addr = AXI_ADDR_WIDTH'(s_axis_res_instr_tdata[INSTR_ADDR_LSB +: INSTR_ADDR_W]);
         load_rem  = s_axis_res_instr_tdata[INSTR_CNT_LSB +: INSTR_CNT_W];
      end else begin
         load_addr = cur_addr_q + (AXI_ADDR_WIDTH'(len_q) << SIZE_LOG2);
         load_rem  = remaining_q - 16'(len_q);
      end
   end

   res_burst_calc #(
      .DATA_BYTES    (DATA_BYTES),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) u_burst_calc (
      .remaining_i (load_rem),
      .addr_lo_i   (load_addr[11:0]),
      .len_o       (calc_len)
   );

   assign last_beat  = (beat_q == len_q - 9'd1);
   assign final_beat = last_beat && (remaining_q == 16'(len_q));

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      len_d        = len_q;
      beat_d       = beat_q;
      tuser_d      = tuser_q;
      instr_done_d = 1'b0;
      layer_done_d = 1'b0;
      err_resp_d   = err_resp_q;
      err_len_d    = err_len_q;

      s_axis_res_instr_tready = 1'b0;
      s_axis_lc2res_tready    = 1'b0;
      m_axi_awaddr            = '0;
      m_axi_awlen             = 8'd0;
      m_axi_awsize            = 3'd0;
      m_axi_awburst           = 2'b00;
      m_axi_awvalid           = 1'b0;
      m_axi_wdata             = '0;
      m_axi_wstrb             = '0;
      m_axi_wlast             = 1'b0;
      m_axi_wvalid            = 1'b0;
      m_axi_bready            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // run_q keeps the instruction port closed for the first cycle out of reset
            s_axis_res_instr_tready = run_q;
            if (run_q && s_axis_res_instr_tvalid) begin
               cur_addr_d  = load_addr;
               remaining_d = load_rem;
               tuser_d     = 1'b0;
               if (load_rem == 16'd0) begin
                  instr_done_d = 1'b1;
               end else begin
                  state_d = ST_ADDR;
                  len_d   = calc_len;
                  beat_d  = 9'd0;
               end
            end
         end
         ST_ADDR: begin
            m_axi_awvalid = 1'b1;
            m_axi_awaddr  = cur_addr_q;
            m_axi_awlen   = 8'(len_q - 9'd1);
            m_axi_awsize  = 3'(SIZE_LOG2);
            m_axi_awburst = AXI_BURST_INCR;
            if (m_axi_awready) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            m_axi_wvalid         = s_axis_lc2res_tvalid;
            s_axis_lc2res_tready = m_axi_wready;
            m_axi_wdata          = s_axis_lc2res_tdata;
            m_axi_wstrb          = s_axis_lc2res_tkeep;
            m_axi_wlast          = last_beat;
            if (s_axis_lc2res_tvalid && m_axi_wready) begin
               beat_d = beat_q + 9'd1;
               if (s_axis_lc2res_tlast != final_beat) begin
                  err_len_d = 1'b1;
               end
               if (final_beat) begin
                  tuser_d = s_axis_lc2res_tuser;
               end
               if (last_beat) begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               if (m_axi_bresp != AXI_RESP_OKAY) begin
                  err_resp_d = 1'b1;
               end
               cur_addr_d  = load_addr;
               remaining_d = load_rem;
               if (load_rem == 16'd0) begin
                  state_d      = ST_IDLE;
                  instr_done_d = 1'b1;
                  layer_done_d = tuser_q;
               end else begin
                  state_d = ST_ADDR;
                  len_d   = calc_len;
                  beat_d  = 9'd0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= 16'd0;
         len_q        <= 9'd0;
         beat_q       <= 9'd0;
         tuser_q      <= 1'b0;
         instr_done_q <= 1'b0;
         layer_done_q <= 1'b0;
         err_resp_q   <= 1'b0;
         err_len_q    <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         tuser_q      <= tuser_d;
         instr_done_q <= instr_done_d;
         layer_done_q <= layer_done_d;
         err_resp_q   <= err_resp_d;
         err_len_q    <= err_len_d;
         run_q        <= 1'b1;
      end
   end

   assign instr_done = instr_done_q;
   assign layer_done = layer_done_q;
   assign err_resp   = err_resp_q;
   assign err_len    = err_len_q;

endmodule

// File: tb/tb_res_writer.sv
// Scoreboard bench for res_writer: directed instructions push expected AW/W/done
// entries into queues, and a negedge monitor pops and compares them as the DUT fires.
module tb_res_writer;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int IW = 64;
   localparam int KW = DW / 8;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } aw_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } w_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic          s_axis_res_instr_tvalid;
   logic          s_axis_res_instr_tready;
   logic [IW-1:0] s_axis_res_instr_tdata;
   logic          s_axis_lc2res_tvalid;
   logic          s_axis_lc2res_tready;
   logic [DW-1:0] s_axis_lc2res_tdata;
   logic [KW-1:0] s_axis_lc2res_tkeep;
   logic          s_axis_lc2res_tlast;
   logic          s_axis_lc2res_tuser;
   logic [AW-1:0] m_axi_awaddr;
   logic [7:0]    m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic          m_axi_awvalid;
   logic          m_axi_awready;
   logic [DW-1:0] m_axi_wdata;
   logic [KW-1:0] m_axi_wstrb;
   logic          m_axi_wlast;
   logic          m_axi_wvalid;
   logic          m_axi_wready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid;
   logic          m_axi_bready;
   logic          instr_done;
   logic          layer_done;
   logic          err_resp;
   logic          err_len;

   aw_t        exp_aw[$];
   w_t         exp_w[$];
   logic       exp_done[$];
   beat_t      stream_q[$];
   logic [1:0] bresp_q[$];

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_evt_cyc = 0;
   int         b_pending = 0;
   int         w_seen = 0;
   bit         stall_en = 0;
   bit         aw_open = 0;
   bit         s_fire = 0;
   bit         w_last_fire = 0;
   bit         b_fire = 0;
   bit         prev_aw_wait = 0;
   logic [AW-1:0] prev_awaddr = '0;
   logic [7:0]    prev_awlen = '0;

   res_writer dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .s_axis_res_instr_tvalid (s_axis_res_instr_tvalid),
      .s_axis_res_instr_tready (s_axis_res_instr_tready),
      .s_axis_res_instr_tdata  (s_axis_res_instr_tdata),
      .s_axis_lc2res_tvalid    (s_axis_lc2res_tvalid),
      .s_axis_lc2res_tready    (s_axis_lc2res_tready),
      .s_axis_lc2res_tdata     (s_axis_lc2res_tdata),
      .s_axis_lc2res_tkeep     (s_axis_lc2res_tkeep),
      .s_axis_lc2res_tlast     (s_axis_lc2res_tlast),
      .s_axis_lc2res_tuser     (s_axis_lc2res_tuser),
      .m_axi_awaddr            (m_axi_awaddr),
      .m_axi_awlen             (m_axi_awlen),
      .m_axi_awsize            (m_axi_awsize),
      .m_axi_awburst           (m_axi_awburst),
      .m_axi_awvalid           (m_axi_awvalid),
      .m_axi_awready           (m_axi_awready),
      .m_axi_wdata             (m_axi_wdata),
      .m_axi_wstrb             (m_axi_wstrb),
      .m_axi_wlast             (m_axi_wlast),
      .m_axi_wvalid            (m_axi_wvalid),
      .m_axi_wready            (m_axi_wready),
      .m_axi_bresp             (m_axi_bresp),
      .m_axi_bvalid            (m_axi_bvalid),
      .m_axi_bready            (m_axi_bready),
      .instr_done              (instr_done),
      .layer_done              (layer_done),
      .err_resp                (err_resp),
      .err_len                 (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] beatData(input int tag, input int idx);
      logic [7:0] t8;
      logic [7:0] i8;
      t8 = 8'(tag);
      i8 = 8'(idx);
      return {8{t8, i8}};
   endfunction

   // Monitor: samples at negedge, pops expectations for every handshake that completes on the next edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            s_fire       = 0;
            w_last_fire  = 0;
            b_fire       = 0;
            prev_aw_wait = 0;
         end else begin
            if (m_axi_wvalid || s_axis_lc2res_tready) begin
               checkOutput("w_before_aw", DW'(aw_open), DW'(1));
            end
            if (prev_aw_wait && m_axi_awvalid) begin
               checkOutput("awaddr_hold", DW'(m_axi_awaddr), DW'(prev_awaddr));
               checkOutput("awlen_hold", DW'(m_axi_awlen), DW'(prev_awlen));
            end
            prev_aw_wait = m_axi_awvalid && !m_axi_awready;
            prev_awaddr  = m_axi_awaddr;
            prev_awlen   = m_axi_awlen;

            if (s_axis_res_instr_tvalid && s_axis_res_instr_tready) begin
               last_evt_cyc = cyc;
            end

            if (m_axi_awvalid && m_axi_awready) begin
               if (exp_aw.size() == 0) begin
                  checkOutput("aw_unexpected", DW'(m_axi_awvalid), DW'(0));
               end else begin
                  aw_t e;
                  e = exp_aw.pop_front();
                  checkOutput("awaddr", DW'(m_axi_awaddr), DW'(e.addr));
                  checkOutput("awlen", DW'(m_axi_awlen), DW'(e.len));
                  checkOutput("awsize", DW'(m_axi_awsize), DW'(4));
                  checkOutput("awburst", DW'(m_axi_awburst), DW'(1));
               end
               aw_open = 1;
            end

            w_last_fire = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            if (m_axi_wvalid && m_axi_wready) begin
               w_seen++;
               if (exp_w.size() == 0) begin
                  checkOutput("w_unexpected", DW'(m_axi_wvalid), DW'(0));
               end else begin
                  w_t e;
                  e = exp_w.pop_front();
                  checkOutput("wdata", m_axi_wdata, e.data);
                  checkOutput("wstrb", DW'(m_axi_wstrb), DW'(e.keep));
                  checkOutput("wlast", DW'(m_axi_wlast), DW'(e.last));
               end
               if (m_axi_wlast) aw_open = 0;
            end

            b_fire = m_axi_bvalid && m_axi_bready;
            if (b_fire) last_evt_cyc = cyc;
            s_fire = s_axis_lc2res_tvalid && s_axis_lc2res_tready;

            if (instr_done) begin
               checkOutput("done_latency", DW'(cyc - last_evt_cyc), DW'(1));
               if (exp_done.size() == 0) begin
                  checkOutput("done_unexpected", DW'(instr_done), DW'(0));
               end else begin
                  checkOutput("layer_done", DW'(layer_done), DW'(exp_done.pop_front()));
               end
            end else if (layer_done) begin
               checkOutput("layer_without_instr", DW'(layer_done), DW'(0));
            end
         end
      end
   end

   // AXI slave and stream source, driven just after each rising edge
   initial begin
      m_axi_awready        = 0;
      m_axi_wready         = 0;
      m_axi_bvalid         = 0;
      m_axi_bresp          = 2'b00;
      s_axis_lc2res_tvalid = 0;
      s_axis_lc2res_tdata  = '0;
      s_axis_lc2res_tkeep  = '0;
      s_axis_lc2res_tlast  = 0;
      s_axis_lc2res_tuser  = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            b_pending            = 0;
            m_axi_bvalid         = 0;
            m_axi_bresp          = 2'b00;
            m_axi_awready        = 0;
            m_axi_wready         = 0;
            s_axis_lc2res_tvalid = 0;
         end else begin
            if (w_last_fire) b_pending++;
            if (b_fire) m_axi_bvalid = 0;
            if (!m_axi_bvalid && b_pending > 0) begin
               m_axi_bvalid = 1;
               m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
               b_pending--;
            end
            m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_fire && stream_q.size() > 0) void'(stream_q.pop_front());
            if (stream_q.size() > 0) begin
               s_axis_lc2res_tvalid = 1;
               s_axis_lc2res_tdata  = stream_q[0].data;
               s_axis_lc2res_tkeep  = stream_q[0].keep;
               s_axis_lc2res_tlast  = stream_q[0].last;
               s_axis_lc2res_tuser  = stream_q[0].user;
            end else begin
               s_axis_lc2res_tvalid = 0;
            end
         end
      end
   end

   task automatic sendInstr(input logic [31:0] addr, input int cnt);
      bit got;
      got = 0;
      @(posedge clk);
      #2;
      s_axis_res_instr_tvalid = 1;
      s_axis_res_instr_tdata  = {16'h0000, 16'(cnt), addr};
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_axis_res_instr_tready) begin
            got = 1;
            break;
         end
      end
      if (!got) checkOutput("instr_accept_timeout", DW'(s_axis_res_instr_tready), DW'(1));
      @(posedge clk);
      #2;
      s_axis_res_instr_tvalid = 0;
   endtask

   // Queues the stream beats and the hand-computed bursts, then issues the instruction
   task automatic applyStimulus(input int tag, input logic [31:0] addr, input int cnt,
                                input int tlast_beat, input bit tuser_final, input int nb,
                                input logic [31:0] a0, input int l0,
                                input logic [31:0] a1, input int l1, input logic [1:0] bresp0);
      int idx;
      for (int i = 0; i < cnt; i++) begin
         beat_t b;
         b.data = beatData(tag, i);
         b.keep = KW'({8'(tag), 8'(i)});
         b.last = (i == tlast_beat);
         b.user = tuser_final && (i == cnt - 1);
         stream_q.push_back(b);
      end
      idx = 0;
      for (int k = 0; k < nb; k++) begin
         aw_t a;
         int  l;
         l      = (k == 0) ? l0 : l1;
         a.addr = (k == 0) ? a0 : a1;
         a.len  = 8'(l - 1);
         exp_aw.push_back(a);
         bresp_q.push_back((k == 0) ? bresp0 : 2'b00);
         for (int j = 0; j < l; j++) begin
            w_t w;
            w.data = beatData(tag, idx);
            w.keep = KW'({8'(tag), 8'(idx)});
            w.last = (j == l - 1);
            exp_w.push_back(w);
            idx++;
         end
      end
      exp_done.push_back(tuser_final);
      sendInstr(addr, cnt);
   endtask

   task automatic waitDone(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #3;
         if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_done.size() == 0 &&
             b_pending == 0 && !m_axi_bvalid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checkOutput({"timeout_", name}, DW'(exp_done.size()), DW'(0));
         exp_aw.delete();
         exp_w.delete();
         exp_done.delete();
         stream_q.delete();
         bresp_q.delete();
      end
   endtask

   initial begin
      #1000000;
      n_err++;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n                   = 0;
      s_axis_res_instr_tvalid = 0;
      s_axis_res_instr_tdata  = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_awvalid", DW'(m_axi_awvalid), DW'(0));
      checkOutput("rst_instr_tready", DW'(s_axis_res_instr_tready), DW'(0));
      checkOutput("rst_bready", DW'(m_axi_bready), DW'(0));
      checkOutput("rst_instr_done", DW'(instr_done), DW'(0));
      rst_n = 1;
      repeat (2) @(negedge clk);

      $display("[TB] 20 beats at 0x1000");
      applyStimulus(1, 32'h1000, 20, 19, 0, 2, 32'h1000, 16, 32'h1100, 4, 2'b00);
      waitDone("t1");

      $display("[TB] 8 beats at 0x0FC0 across a 4 KB page");
      applyStimulus(2, 32'h0FC0, 8, 7, 0, 2, 32'h0FC0, 4, 32'h1000, 4, 2'b00);
      waitDone("t2");
      checkOutput("err_resp_clean", DW'(err_resp), DW'(0));
      checkOutput("err_len_clean", DW'(err_len), DW'(0));

      $display("[TB] 32 beats with SLVERR on the first burst");
      applyStimulus(3, 32'h2000, 32, 31, 0, 2, 32'h2000, 16, 32'h2100, 16, 2'b10);
      waitDone("t3");
      checkOutput("err_resp_set", DW'(err_resp), DW'(1));
      checkOutput("err_len_still_clear", DW'(err_len), DW'(0));

      $display("[TB] 4 beats with early tlast");
      applyStimulus(4, 32'h5000, 4, 2, 0, 1, 32'h5000, 4, 32'h0, 0, 2'b00);
      waitDone("t4");
      checkOutput("err_len_set", DW'(err_len), DW'(1));
      checkOutput("err_resp_sticky", DW'(err_resp), DW'(1));

      $display("[TB] zero-beat instruction");
      applyStimulus(5, 32'h6000, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checkOutput("cnt0_no_aw", DW'(m_axi_awvalid), DW'(0));
      end
      waitDone("t5");

      $display("[TB] single beat with tuser");
      applyStimulus(6, 32'h7000, 1, 0, 1, 1, 32'h7000, 1, 32'h0, 0, 2'b00);
      waitDone("t6");

      $display("[TB] reset during data beat 5");
      begin
         int  base;
         bit  hit;
         base = w_seen;
         hit  = 0;
         applyStimulus(7, 32'h3000, 16, 15, 0, 1, 32'h3000, 16, 32'h0, 0, 2'b00);
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (w_seen - base == 6) begin
               hit = 1;
               break;
            end
         end
         checkOutput("reached_beat5", DW'(hit), DW'(1));
         rst_n = 0;
         #1;
         checkOutput("mid_rst_awvalid", DW'(m_axi_awvalid), DW'(0));
         checkOutput("mid_rst_awaddr", DW'(m_axi_awaddr), DW'(0));
         checkOutput("mid_rst_wvalid", DW'(m_axi_wvalid), DW'(0));
         checkOutput("mid_rst_wlast", DW'(m_axi_wlast), DW'(0));
         checkOutput("mid_rst_bready", DW'(m_axi_bready), DW'(0));
         checkOutput("mid_rst_lc_tready", DW'(s_axis_lc2res_tready), DW'(0));
         checkOutput("mid_rst_instr_tready", DW'(s_axis_res_instr_tready), DW'(0));
         checkOutput("mid_rst_instr_done", DW'(instr_done), DW'(0));
         checkOutput("mid_rst_layer_done", DW'(layer_done), DW'(0));
         checkOutput("mid_rst_err_resp", DW'(err_resp), DW'(0));
         checkOutput("mid_rst_err_len", DW'(err_len), DW'(0));
         exp_aw.delete();
         exp_w.delete();
         exp_done.delete();
         stream_q.delete();
         bresp_q.delete();
         aw_open = 0;
         repeat (3) @(negedge clk);
         rst_n = 1;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_awvalid", DW'(m_axi_awvalid), DW'(0));
            checkOutput("post_rst_wvalid", DW'(m_axi_wvalid), DW'(0));
         end
      end

      $display("[TB] 24 beats at 0x4000 with random stalls");
      stall_en = 1;
      applyStimulus(8, 32'h4000, 24, 23, 0, 2, 32'h4000, 16, 32'h4100, 8, 2'b00);
      waitDone("t8");
      checkOutput("final_err_resp", DW'(err_resp), DW'(0));
      checkOutput("final_err_len", DW'(err_len), DW'(0));

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/res_writer.md
RES_WRITER -- requirements
Module: res_writer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default `DFLT_CORE_AXI_DATA_WIDTH (128), the data-bus and W-channel width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, the AXI address width.
REQ-003 SHALL have parameter CORE_INSTR_WIDTH, default `DFLT_CORE_INSTR_WIDTH (64), the instruction width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16, the maximum beats per AXI burst (power of 2, at most 256).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports s_axis_res_instr_tvalid/tready/tdata, in/out/in, 1/1/CORE_INSTR_WIDTH: instruction stream, {reserved[63:48], beat_cnt[47:32], base_addr[31:0]}.
REQ-008 SHALL have ports s_axis_lc2res_tvalid/tready/tdata/tkeep/tlast/tuser, in/out/in/in/in/in, 1/1/AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1: result stream from the layout converter.
REQ-009 SHALL have ports m_axi_awaddr/awlen/awsize/awburst/awvalid, out, AXI_ADDR_WIDTH/8/3/2/1, and m_axi_awready, in, 1: AXI4 write-address channel.
REQ-010 SHALL have ports m_axi_wdata/wstrb/wlast/wvalid, out, AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1, and m_axi_wready, in, 1: AXI4 write-data channel.
REQ-011 SHALL have ports m_axi_bresp/bvalid, in, 2/1, and m_axi_bready, out, 1: AXI4 write-response channel.
REQ-012 SHALL have outputs instr_done, layer_done, err_resp, err_len, 1 bit each: status pulses and sticky flags.

Function
REQ-013 SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> (ADDR if beats remain, else IDLE), with at most one burst outstanding.
REQ-014 In IDLE, s_axis_res_instr_tready SHALL be 1; on handshake, it SHALL latch base_addr into cur_addr and beat_cnt into remaining.
REQ-015 beat_cnt==0 SHALL consume the instruction, pulse instr_done the next cycle, and stay in IDLE.
REQ-016 Burst length SHALL be min(remaining, MAX_BURST_LEN, (4096 - cur_addr[11:0])/(AXI_DATA_WIDTH/8)); a burst SHALL never cross a 4 KB boundary.
REQ-017 In ADDR: awvalid=1, awlen=len-1, awsize=log2(AXI_DATA_WIDTH/8), awburst=INCR (2'b01), awaddr=cur_addr; on awready it SHALL move to DATA; awaddr/awlen SHALL be held stable while awvalid=1.
REQ-018 In DATA: wvalid=lc2res_tvalid, lc2res_tready=wready, wdata=tdata, wstrb=tkeep (combinational pass-through, zero latency).
REQ-019 In DATA, wlast SHALL be 1 exactly on beat index len-1; after that handshake the FSM SHALL move to RESP.
REQ-020 Outside DATA, lc2res_tready and wvalid SHALL be 0.
REQ-021 In RESP: bready=1; on bvalid it SHALL update cur_addr += len*bytes and remaining -= len.
REQ-022 bresp != 2'b00 SHALL set err_resp (sticky); processing SHALL continue.
REQ-023 A stream tlast on any beat other than the instruction's final beat, or a missing tlast on the final beat, SHALL set err_len (sticky); data SHALL still be written.
REQ-024 instr_done SHALL pulse one cycle after the B handshake that makes remaining 0.
REQ-025 layer_done SHALL pulse in the same cycle as instr_done when tuser=1 on the instruction's final stream beat (tuser latched on that beat).
REQ-026 If the instruction and stream are both valid in IDLE, the stream SHALL be stalled until ADDR completes.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE; all valid/ready/last outputs, instr_done, layer_done, err_resp, err_len = 0; counters and addresses = 0.
REQ-028 Reset mid-burst SHALL abandon the transaction; no AXI signal SHALL be asserted until a new instruction is accepted after reset release.

Structure
REQ-029 The FSM state enum, the instruction field offsets, and the AXI burst/resp constants SHALL live in the shared core package.
REQ-030 The burst-length computation SHALL be the sub-module res_burst_calc (combinational, registered at the ADDR entry).

Verification
REQ-031 Instruction {addr 0x1000, cnt 20}, 128-bit bus -> bursts awlen 15 @0x1000 and awlen 3 @0x1100; wlast on beats 15 and 19; one instr_done.
REQ-032 Instruction {addr 0x0FC0, cnt 8} -> bursts of 4 @0x0FC0 and 4 @0x1000 (4 KB split).
REQ-033 bresp=2'b10 on the first burst of cnt 32 -> err_resp=1 sticky; second burst still issued; instr_done pulses.
REQ-034 cnt 4 with tlast on beat 2 -> err_len=1; 4 beats written; instr_done pulses.
REQ-035 cnt 0 -> no awvalid; instr_done pulses 1 cycle after the instruction handshake; a final beat with tuser=1 on cnt 1 -> layer_done coincides with instr_done.
REQ-036 rst_n low during DATA beat 5 -> all outputs 0 immediately; a fresh instruction after release completes normally with randomized wready/awready stalls.
